// File: rtl/gauss_filter_if.sv
// Handshake and image bus between a requester and gauss_filter.
interface gauss_filter_if #(
    parameter int unsigned rows       = 4,
    parameter int unsigned cols       = 4,
    parameter int unsigned data_width = 8
);
    logic                              start;
    logic                              image_ready;
    logic [data_width*rows*cols-1:0]   image_in;
    logic [data_width*rows*cols-1:0]   image_out;
    logic                              done;
    logic                              image_out_valid;

    modport master (
        output start, image_ready, image_in,
        input  image_out, done, image_out_valid
    );

    modport slave (
        input  start, image_ready, image_in,
        output image_out, done, image_out_valid
    );
endinterface

// File: rtl/gauss_filter.sv
// 3x3 Gaussian blur over a latched image, one output pixel per clock,
// with edge-replicated borders and round-half-up normalisation.
module gauss_filter #(
    parameter int unsigned rows       = 4,
    parameter int unsigned cols       = 4,
    parameter int unsigned ksize      = 3,
    parameter int unsigned data_width = 8
) (
    input  logic          clk,
    input  logic          rst,
    gauss_filter_if.slave bus
);
    localparam int unsigned npix  = rows * cols;
    localparam int unsigned img_w = data_width * npix;
    localparam int unsigned row_w = (rows > 1) ? $clog2(rows) : 1;
    localparam int unsigned col_w = (cols > 1) ? $clog2(cols) : 1;
    // Any kernel size other than 3 leaves the block permanently idle.
    localparam bit ksize_ok = (ksize == 3);

    typedef logic [data_width+3:0] sum_t;
    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

    state_e             state_q, state_d;
    logic [img_w-1:0]   buf_q;
    logic [img_w-1:0]   image_out_q;
    logic [row_w-1:0]   row_q;
    logic [col_w-1:0]   col_q;

    logic               accept;
    logic               last_col;
    logic               last_pix;
    logic [data_width-1:0] pix_out;
    int unsigned        pix_idx;
    int unsigned        r, c, rm, rp, cm, cp;
    sum_t               sum;

    function automatic sum_t tap(input logic [img_w-1:0] img, input int unsigned pr,
                                 input int unsigned pc);
        return sum_t'(img[(pr * cols + pc) * data_width +: data_width]);
    endfunction

    assign accept = bus.start && bus.image_ready && ksize_ok && (state_q != StCompute);

    // Weighted 3x3 sum for the current pixel, neighbours clamped to the image.
    always_comb begin
        r        = 32'(row_q);
        c        = 32'(col_q);
        rm       = (r == 32'd0) ? 32'd0 : r - 32'd1;
        rp       = (r == rows - 1) ? r : r + 32'd1;
        cm       = (c == 32'd0) ? 32'd0 : c - 32'd1;
        cp       = (c == cols - 1) ? c : c + 32'd1;
        sum      = tap(buf_q, rm, cm) + (tap(buf_q, rm, c) << 1) + tap(buf_q, rm, cp)
                 + (tap(buf_q, r, cm) << 1) + (tap(buf_q, r, c) << 2)
                 + (tap(buf_q, r, cp) << 1)
                 + tap(buf_q, rp, cm) + (tap(buf_q, rp, c) << 1) + tap(buf_q, rp, cp);
        // Max 16*(2^w-1)+8 still fits in w+4 bits, so no saturation.
        sum      = sum + sum_t'(8);
        pix_out  = sum[data_width+3:4];
        pix_idx  = r * cols + c;
        last_col = (c == cols - 1);
        last_pix = last_col && (r == rows - 1);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (accept) state_d = StCompute;
            StCompute:      if (last_pix) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // FSM outputs: result flags are high only while a finished result is held.
    always_comb begin
        bus.done            = (state_q == StDone);
        bus.image_out_valid = (state_q == StDone);
    end

    assign bus.image_out = image_out_q;

    // Datapath: latch the image on accept, then write one pixel per clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q       <= '0;
            image_out_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else if (accept) begin
            buf_q <= bus.image_in;
            row_q <= '0;
            col_q <= '0;
        end else if (state_q == StCompute) begin
            image_out_q[pix_idx * data_width +: data_width] <= pix_out;
            if (last_col) begin
                col_q <= '0;
                row_q <= last_pix ? '0 : row_q + row_w'(1);
            end else begin
                col_q <= col_q + col_w'(1);
            end
        end
    end
endmodule

// File: tb/tb_gauss_filter.sv
// Self-checking bench for gauss_filter: directed and random images checked
// against a plain-arithmetic 2D convolution model.
module tb_gauss_filter;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int NB   = ROWS * COLS * DW;

    typedef logic [NB-1:0] img_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    gauss_filter_if #(.rows(ROWS), .cols(COLS), .data_width(DW)) bus ();

    gauss_filter #(.rows(ROWS), .cols(COLS), .ksize(3), .data_width(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] px(input img_t img, input int r, input int c);
        return img[(r * COLS + c) * DW +: DW];
    endfunction

    function automatic img_t fill(input logic [7:0] v);
        img_t img;
        for (int i = 0; i < ROWS * COLS; i++) img[i * DW +: DW] = v;
        return img;
    endfunction

    function automatic img_t rand_img();
        img_t img;
        for (int i = 0; i < ROWS * COLS; i++)
            img[i * DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        return img;
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Reference: separable 1-2-1 weights, replicated borders, round half up.
    function automatic img_t model(input img_t img);
        img_t out;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int acc;
                acc = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        acc += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1)
                             * int'(px(img, clampi(r + dr, ROWS - 1), clampi(c + dc, COLS - 1)));
                out[(r * COLS + c) * DW +: DW] = 8'((acc + 8) / 16);
            end
        end
        return out;
    endfunction

    // Present an image with start+ready for one edge, then scramble image_in.
    task automatic do_accept(input img_t img);
        bus.image_in    = img;
        bus.start       = 1'b1;
        bus.image_ready = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.image_ready = 1'b0;
        bus.image_in    = ~img;
    endtask

    // Cycles until done rises, or -1 if it never does within the budget.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst             = 1'b0;
        bus.start       = 1'b0;
        bus.image_ready = 1'b0;
        bus.image_in    = '0;
        #12;
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL reset_done: got %b want 0", bus.done);
        end
        total++;
        if (bus.image_out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b want 0", bus.image_out_valid);
        end
        total++;
        if (bus.image_out !== img_t'(0)) begin
            bad++; $display("FAIL reset_image: got %h want 0", bus.image_out);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_no_ready();
        bit seen;
        seen            = 1'b0;
        bus.image_in    = fill(8'h55);
        bus.start       = 1'b1;
        bus.image_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        bus.start = 1'b0;
        total++;
        if (seen) begin
            bad++; $display("FAIL no_ready_done: got 1 want 0 over 20 cycles");
        end
        total++;
        if (bus.image_out !== img_t'(0)) begin
            bad++; $display("FAIL no_ready_image: got %h want 0", bus.image_out);
        end
    endtask

    task automatic test_directed();
        img_t imgs[3];
        img_t exp_img;
        int   n;
        imgs[0] = fill(8'h80);
        imgs[1] = '0;
        imgs[1][(1 * COLS + 1) * DW +: DW] = 8'hFF;
        imgs[2] = '0;
        imgs[2][7:0] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            exp_img = model(imgs[k]);
            do_accept(imgs[k]);
            total++;
            if (bus.done !== 1'b0) begin
                bad++; $display("FAIL dir%0d_done_clear: got %b want 0", k, bus.done);
            end
            wait_done(n);
            total++;
            if (n !== 16) begin
                bad++; $display("FAIL dir%0d_latency: got %0d want 16", k, n);
            end
            total++;
            if (bus.image_out !== exp_img) begin
                bad++; $display("FAIL dir%0d_image: got %h want %h", k, bus.image_out, exp_img);
            end
            total++;
            if (bus.image_out_valid !== 1'b1) begin
                bad++; $display("FAIL dir%0d_valid: got %b want 1", k, bus.image_out_valid);
            end
        end
        // Spot values: last result is the corner image.
        total++;
        if (px(bus.image_out, 0, 0) !== 8'h8F || px(bus.image_out, 0, 1) !== 8'h30 ||
            px(bus.image_out, 1, 0) !== 8'h30 || px(bus.image_out, 1, 1) !== 8'h10) begin
            bad++; $display("FAIL corner_values: got %h want 8f/30/30/10 at (0,0)(0,1)(1,0)(1,1)",
                            bus.image_out);
        end
        // Result and flags hold in DONE while inputs wiggle.
        exp_img      = bus.image_out;
        bus.image_in = rand_img();
        bus.start    = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        total++;
        if (bus.image_out !== exp_img || bus.done !== 1'b1 || bus.image_out_valid !== 1'b1) begin
            bad++; $display("FAIL done_hold: got %h done=%b want %h done=1",
                            bus.image_out, bus.done, exp_img);
        end
        // Centre impulse spot values.
        do_accept(imgs[1]);
        wait_done(n);
        total++;
        if (px(bus.image_out, 1, 1) !== 8'h40 || px(bus.image_out, 0, 1) !== 8'h20 ||
            px(bus.image_out, 2, 1) !== 8'h20 || px(bus.image_out, 0, 0) !== 8'h10 ||
            px(bus.image_out, 2, 2) !== 8'h10 || px(bus.image_out, 3, 3) !== 8'h00) begin
            bad++; $display("FAIL center_values: got %h", bus.image_out);
        end
    endtask

    task automatic test_second_start();
        img_t a, b, exp_img;
        int   n;
        a       = rand_img();
        b       = rand_img();
        exp_img = model(a);
        do_accept(a);
        repeat (4) begin @(posedge clk); #1; end
        bus.image_in    = b;
        bus.start       = 1'b1;
        bus.image_ready = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.image_ready = 1'b0;
        wait_done(n);
        total++;
        if (n !== 11) begin
            bad++; $display("FAIL second_start_latency: got %0d want 11 after pulse", n);
        end
        total++;
        if (bus.image_out !== exp_img) begin
            bad++; $display("FAIL second_start_image: got %h want %h", bus.image_out, exp_img);
        end
    endtask

    task automatic test_reset_mid();
        img_t b, exp_img;
        int   n;
        do_accept(rand_img());
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        total++;
        if (bus.image_out !== img_t'(0) || bus.done !== 1'b0 || bus.image_out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got %h done=%b valid=%b want 0/0/0",
                            bus.image_out, bus.done, bus.image_out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL reset_mid_idle: got %b want 0", bus.done);
        end
        b       = rand_img();
        exp_img = model(b);
        do_accept(b);
        wait_done(n);
        total++;
        if (n !== 16 || bus.image_out !== exp_img) begin
            bad++; $display("FAIL reset_mid_rerun: got n=%0d %h want n=16 %h",
                            n, bus.image_out, exp_img);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_accept(fill(8'h80));
        wait_done(n);
        total++;
        if (bus.image_out !== fill(8'h80)) begin
            bad++; $display("FAIL b2b_first: got %h want all 80", bus.image_out);
        end
        do_accept(fill(8'h20));
        total++;
        if (bus.done !== 1'b0 || bus.image_out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drop: got done=%b valid=%b want 0/0",
                            bus.done, bus.image_out_valid);
        end
        wait_done(n);
        total++;
        if (n !== 16) begin
            bad++; $display("FAIL b2b_latency: got %0d want 16", n);
        end
        total++;
        if (bus.image_out !== fill(8'h20)) begin
            bad++; $display("FAIL b2b_image: got %h want all 20", bus.image_out);
        end
    endtask

    task automatic test_random();
        img_t img, exp_img;
        int   n;
        for (int k = 0; k < 8; k++) begin
            img     = rand_img();
            exp_img = model(img);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            do_accept(img);
            wait_done(n);
            total++;
            if (n !== 16 || bus.image_out !== exp_img) begin
                bad++; $display("FAIL random%0d: got n=%0d %h want n=16 %h",
                                k, n, bus.image_out, exp_img);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_ready();
        test_directed();
        test_second_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
